// File: rtl/led_seq_ctrl_pkg.sv
// Shared constants for the LED sequencer: register map, FSM states and display modes.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package led_seq_ctrl_pkg;

    localparam logic [11:0] LED_PAT_ADDR    = 12'h060;
    localparam logic [11:0] LED_CTRL_ADDR   = 12'h064;
    localparam logic [11:0] LED_PERIOD_ADDR = 12'h068;
    localparam logic [11:0] LED_STAT_ADDR   = 12'h06C;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_ROL    = 2'd2;
    localparam logic [1:0] MODE_ROR    = 2'd3;

    // A full rotation of the 24-bit display takes 24 ticks, so step runs 0..23.
    localparam logic [4:0] STEP_LAST = 5'd23;

    // Next display word on a tick; blink alternates between the pattern and dark.
    function automatic logic [23:0] step_disp(input logic [1:0]  mode,
                                              input logic [23:0] disp,
                                              input logic [23:0] pattern);
        case (mode)
            MODE_BLINK: return (disp == pattern) ? 24'h0 : pattern;
            MODE_ROL:   return {disp[22:0], disp[23]};
            MODE_ROR:   return {disp[0], disp[23:1]};
            default:    return disp;
        endcase
    endfunction

endpackage

// File: rtl/led_seq_ctrl_if.sv
// Register bus between a host and the LED sequencer.
// Latency: writes take effect on the next rising edge; read data is combinational.
// Backpressure: none, every access completes in the cycle io_en is high.
interface led_seq_ctrl_if;
    logic        io_en;
    logic        io_we;
    logic [11:0] io_addr;
    logic [31:0] io_write_data;
    logic [31:0] io_read_data;

    modport master (output io_en, io_we, io_addr, io_write_data, input io_read_data);
    modport slave  (input io_en, io_we, io_addr, io_write_data, output io_read_data);
endinterface

// File: rtl/led_tick_gen.sv
// Prescaler: pulses tick once every max(period,1) enabled cycles.
// Latency: tick is combinational from the counter; counter updates on the rising edge.
// Backpressure: none; clr restarts the count and suppresses the tick of that cycle.
module led_tick_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic [31:0] period,
    output logic        tick
);

    logic [31:0] cnt_q, cnt_d;
    logic [31:0] limit;

    // Count 0..limit, wrapping to 0 with a tick; period 0 is treated as period 1.
    always_comb begin
        limit = (period == 32'd0) ? 32'd0 : period - 32'd1;
        tick  = 1'b0;
        cnt_d = cnt_q;
        if (!en || clr) begin
            cnt_d = '0;
        end else if (cnt_q >= limit) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequencer: register file, run/stop FSM and display shifting driven by led_tick_gen.
// Latency: device_led and busy reflect a write or tick one cycle later (registered).
// Backpressure: none; bus accesses always complete, stop beats start when both are written.
module led_seq_ctrl
    import led_seq_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    led_seq_ctrl_if.slave        bus,
    output logic [23:0]          device_led,
    output logic                 busy
);

    logic [23:0] pattern_q, pattern_d;
    logic [1:0]  mode_q, mode_d;
    logic        oneshot_q, oneshot_d;
    logic [31:0] period_q, period_d;
    logic [23:0] disp_q, disp_d;
    logic [4:0]  step_q, step_d;
    logic [1:0]  state_q, state_d;
    logic [23:0] device_led_q, device_led_d;
    logic        busy_q, busy_d;

    logic wr_pat, wr_ctrl, wr_per, start, stop, tick, tick_en, tick_clr;
    logic [31:0] rd_data;

    // Any CTRL or PERIOD write restarts the prescaler so a new setting gets a full period.
    assign tick_en  = (state_q == ST_RUN);
    assign tick_clr = wr_ctrl || wr_per;

    led_tick_gen u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (tick_en),
        .clr    (tick_clr),
        .period (period_q),
        .tick   (tick)
    );

    // Register writes, FSM transitions and the display update.
    always_comb begin
        wr_pat  = bus.io_en && bus.io_we && (bus.io_addr == LED_PAT_ADDR);
        wr_ctrl = bus.io_en && bus.io_we && (bus.io_addr == LED_CTRL_ADDR);
        wr_per  = bus.io_en && bus.io_we && (bus.io_addr == LED_PERIOD_ADDR);
        start   = wr_ctrl && bus.io_write_data[2];
        stop    = wr_ctrl && bus.io_write_data[3];

        pattern_d = wr_pat  ? bus.io_write_data[23:0] : pattern_q;
        mode_d    = wr_ctrl ? bus.io_write_data[1:0]  : mode_q;
        oneshot_d = wr_ctrl ? bus.io_write_data[4]    : oneshot_q;
        period_d  = wr_per  ? bus.io_write_data       : period_q;

        disp_d  = disp_q;
        step_d  = step_q;
        state_d = state_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d = ST_RUN;
                    disp_d  = pattern_q;
                    step_d  = '0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;          // step left as-is for readback
                end else if (start) begin
                    disp_d = pattern_q;         // restart in place
                    step_d = '0;
                end else if (tick) begin
                    disp_d = step_disp(mode_q, disp_q, pattern_q);
                    if (step_q == STEP_LAST) begin
                        step_d = '0;
                        if (oneshot_q) state_d = ST_DONE;
                    end else begin
                        step_d = step_q + 5'd1;
                    end
                end
                // A new pattern takes over the display immediately, winning over a tick.
                if (wr_pat) disp_d = bus.io_write_data[23:0];
            end
            default: state_d = ST_IDLE;
        endcase

        device_led_d = (state_d == ST_RUN) ? disp_d : pattern_d;
        busy_d       = (state_d == ST_RUN);
    end

    // All sequencer state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q    <= '0;
            mode_q       <= MODE_STATIC;
            oneshot_q    <= 1'b0;
            period_q     <= '0;
            disp_q       <= '0;
            step_q       <= '0;
            state_q      <= ST_IDLE;
            device_led_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            pattern_q    <= pattern_d;
            mode_q       <= mode_d;
            oneshot_q    <= oneshot_d;
            period_q     <= period_d;
            disp_q       <= disp_d;
            step_q       <= step_d;
            state_q      <= state_d;
            device_led_q <= device_led_d;
            busy_q       <= busy_d;
        end
    end

    // Combinational readback; start/stop are pulses and always read as 0.
    always_comb begin
        rd_data = '0;
        if (bus.io_en) begin
            case (bus.io_addr)
                LED_PAT_ADDR:    rd_data = {8'h0, pattern_q};
                LED_CTRL_ADDR:   rd_data = {27'h0, oneshot_q, 2'b00, mode_q};
                LED_PERIOD_ADDR: rd_data = period_q;
                LED_STAT_ADDR:   rd_data = {25'h0, step_q, state_q};
                default:         rd_data = '0;
            endcase
        end
    end

    assign bus.io_read_data = rd_data;
    assign device_led       = device_led_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Testbench for led_seq_ctrl: scripted register traffic with a scoreboard of expected values.
// Latency: samples 1 time unit after the rising edge, reads mid-cycle.
// Backpressure: n/a.
module tb_led_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic [23:0] device_led;
    logic        busy;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q[$];
    logic [31:0] rd;

    led_seq_ctrl_if bus_if ();

    led_seq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_if),
        .device_led (device_led),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [31:0] v);
        sb_q.push_back(v);
    endtask

    task automatic sb_pop(input string tag, input logic [31:0] obs);
        if (sb_q.size() == 0) chk({tag, "_no_expectation"}, 32'(sb_q.size()), 32'd1);
        else                  chk(tag, obs, sb_q.pop_front());
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic io_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.io_en         = 1'b1;
        bus_if.io_we         = 1'b1;
        bus_if.io_addr       = a;
        bus_if.io_write_data = d;
        @(posedge clk);
        #1;
        bus_if.io_en = 1'b0;
        bus_if.io_we = 1'b0;
    endtask

    // Read with an expectation: pushed when the access is driven, popped when data is sampled.
    task automatic io_read_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        @(negedge clk);
        bus_if.io_en   = 1'b1;
        bus_if.io_we   = 1'b0;
        bus_if.io_addr = a;
        sb_push(exp);
        #1;
        rd = bus_if.io_read_data;
        sb_pop(tag, rd);
        bus_if.io_en = 1'b0;
    endtask

    task automatic led_chk(input string tag, input int n, input logic [23:0] exp_led, input logic exp_busy);
        sb_push({8'h0, exp_led});
        cycles(n);
        sb_pop(tag, {8'h0, device_led});
        chk({tag, "_busy"}, {31'h0, busy}, {31'h0, exp_busy});
    endtask

    initial begin
        rst_n                = 1'b0;
        bus_if.io_en         = 1'b0;
        bus_if.io_we         = 1'b0;
        bus_if.io_addr       = '0;
        bus_if.io_write_data = '0;
        #1;
        chk("rst_led", {8'h0, device_led}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cycles(1);

        // Reset state after release
        led_chk("idle_led", 1, 24'h0, 1'b0);
        io_read_chk("rst_stat", 12'h06C, 32'h0);
        io_read_chk("rst_period", 12'h068, 32'h0);
        io_read_chk("rst_ctrl", 12'h064, 32'h0);

        // Static pattern shows one cycle after the write
        sb_push(32'h0000A5A5);
        io_write(12'h060, 32'h0000A5A5);
        sb_pop("pat_led", {8'h0, device_led});
        chk("pat_busy", {31'h0, busy}, 32'h0);

        // Rotate-left, period 3
        io_write(12'h060, 32'h1);
        io_write(12'h068, 32'd3);
        io_write(12'h064, 32'h2);
        io_write(12'h064, 32'h6);
        chk("rol_start_led", {8'h0, device_led}, 32'h1);
        led_chk("rol_t1", 3, 24'h000002, 1'b1);
        led_chk("rol_t2", 3, 24'h000004, 1'b1);
        io_read_chk("rol_stat", 12'h06C, {25'h0, 5'd2, 2'd1});
        io_write(12'h064, 32'h0A);
        io_read_chk("rol_stop_stat", 12'h06C, {25'h0, 5'd2, 2'd0});

        // Rotate-right oneshot, period 0
        io_write(12'h060, 32'h800000);
        io_write(12'h068, 32'd0);
        io_write(12'h064, 32'h17);
        led_chk("ror_first", 1, 24'h400000, 1'b1);
        led_chk("ror_23", 22, 24'h000001, 1'b1);
        led_chk("ror_done", 1, 24'h800000, 1'b0);
        io_read_chk("ror_done_stat", 12'h06C, {25'h0, 5'd0, 2'd2});
        io_write(12'h064, 32'h08);
        io_read_chk("done_stop_stat", 12'h06C, 32'h0);

        // Blink, period 2, then stop
        io_write(12'h060, 32'hFFFFFF);
        io_write(12'h068, 32'd2);
        io_write(12'h064, 32'h05);
        chk("blink_start_led", {8'h0, device_led}, 32'hFFFFFF);
        led_chk("blink_off1", 2, 24'h000000, 1'b1);
        led_chk("blink_on", 2, 24'hFFFFFF, 1'b1);
        led_chk("blink_off2", 2, 24'h000000, 1'b1);
        sb_push(32'hFFFFFF);
        io_write(12'h064, 32'h09);
        sb_pop("blink_stop_led", {8'h0, device_led});
        chk("blink_stop_busy", {31'h0, busy}, 32'h0);
        io_read_chk("blink_stop_stat", 12'h06C, {25'h0, 5'd3, 2'd0});

        // Pattern write colliding with a tick
        io_write(12'h060, 32'h1);
        io_write(12'h068, 32'd0);
        io_write(12'h064, 32'h06);
        chk("coll_start_led", {8'h0, device_led}, 32'h1);
        sb_push(32'h123456);
        io_write(12'h060, 32'h123456);
        sb_pop("coll_led", {8'h0, device_led});
        led_chk("coll_next", 1, 24'h2468AC, 1'b1);
        io_read_chk("ctrl_readback", 12'h064, 32'h2);
        io_read_chk("pat_readback", 12'h060, 32'h123456);

        // Reset mid-run
        io_write(12'h068, 32'd5);
        chk("midrun_busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_led", {8'h0, device_led}, 32'h0);
        chk("arst_busy", {31'h0, busy}, 32'h0);
        io_read_chk("arst_period", 12'h068, 32'h0);
        io_read_chk("arst_stat", 12'h06C, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        led_chk("post_rst_led", 2, 24'h0, 1'b0);

        // Ignored writes and gated reads
        io_write(12'h06C, 32'hFFFFFFFF);
        io_read_chk("stat_ro", 12'h06C, 32'h0);
        io_write(12'h070, 32'h00000007);
        io_read_chk("unmapped_rd", 12'h070, 32'h0);
        io_read_chk("unmapped_no_period", 12'h068, 32'h0);
        io_write(12'h060, 32'h00ABCD);
        @(negedge clk);
        bus_if.io_addr = 12'h060;
        bus_if.io_en   = 1'b0;
        #1;
        chk("rd_gated", bus_if.io_read_data, 32'h0);
        chk("static_led", {8'h0, device_led}, 32'h00ABCD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
